boss_bullet_scheduler: RTL
==========================

BOSS_BULLET_SCHEDULER -- requirements
Module: boss_bullet_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 4: number of boss bullet slots, 1..8.
REQ-002 Parameter FIRE_PERIOD, default 480: ticks between fire events, at least 2.
REQ-003 Parameter Y_LIMIT, default 960: bullet retires when its y is at or above this value.
REQ-004 Parameter STEP, default 1: y increment per tick.
REQ-005 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port tick, input, 1: one-cycle movement/fire-timer strobe, synchronous to clk.
REQ-008 Port boss_exist, input, 1: boss alive.
REQ-009 Ports boss_x and boss_y, input, 10 each: boss top-left position.
REQ-010 Ports hit_valid (input, 1) and hit_slot (input, 3): a collision was reported on slot hit_slot.
REQ-011 Port slot_active, output, NUM_SLOTS: per-slot live flag.
REQ-012 Ports slot_x and slot_y, output, 10*NUM_SLOTS each, packed: slot i occupies bits [10i+9:10i].
REQ-013 Port fire_pulse, output, 1: high for one cycle per fire event.
REQ-014 Port fire_dropped, output, 1: high for one cycle when a fire event finds no free slot.
REQ-015 Port busy_state, output, 2: current FSM state encoding.

Function
REQ-016 The FSM SHALL have four states, encoded IDLE=0, ARMED=1, FIRE=2, FLUSH=3; all outputs are registered.
REQ-017 IDLE SHALL go to ARMED when boss_exist=1, with the counter cleared.
REQ-018 ARMED SHALL increment the 10-bit counter on each tick.
REQ-019 In ARMED, a tick with counter==FIRE_PERIOD-1 SHALL clear the counter and go to FIRE.
REQ-020 FIRE SHALL last exactly one cycle, then return to ARMED.
REQ-021 In FIRE, the lowest-index slot whose slot_active was 0 at the start of the cycle SHALL be loaded with x=boss_x+54 and y=boss_y+60 (10-bit wrap), set active, and fire_pulse SHALL be 1.
REQ-022 In FIRE with no free slot, no slot SHALL change, fire_pulse SHALL stay 0, and fire_dropped SHALL be 1.
REQ-023 From ARMED or FIRE, boss_exist=0 SHALL take priority over all other transitions and go to FLUSH.
REQ-024 FLUSH SHALL clear all slot_active bits in one cycle, then go to IDLE.
REQ-025 On every tick, outside FLUSH, each active slot not hit in that cycle SHALL have y<=y+STEP.
REQ-026 If the new y is at or above Y_LIMIT, that slot SHALL be cleared in the same cycle.
REQ-027 hit_valid with hit_slot<NUM_SLOTS and the slot active SHALL clear that slot next cycle.
REQ-028 A hit on an inactive slot, or with hit_slot>=NUM_SLOTS, SHALL be ignored.
REQ-029 Hit and tick on the same slot in the same cycle: the hit SHALL win; the slot is cleared and not moved.
REQ-030 A slot freed in cycle N SHALL NOT be allocated by a FIRE occurring in cycle N.
REQ-031 A slot's x and y SHALL hold their last value while the slot is inactive.
REQ-032 Ticks arriving in IDLE, FIRE or FLUSH SHALL NOT advance the counter.

Reset
REQ-033 While rst=1 at a clk edge: state=IDLE, counter=0, slot_active=0, all slot_x and slot_y=0, fire_pulse=0, fire_dropped=0.
REQ-034 rst SHALL override every other input, including in-flight FIRE and FLUSH.

Configuration
REQ-035 With BOSS_BULLET_STATS_EN defined, the block SHALL add outputs fired_count[7:0] and dropped_count[7:0].
REQ-036 fired_count and dropped_count SHALL increment on fire_pulse and fire_dropped respectively, saturate at 255, and reset to 0.
REQ-037 Without BOSS_BULLET_STATS_EN, these ports and counters SHALL be absent; all other behaviour is identical.

Verification (NUM_SLOTS=4, FIRE_PERIOD=4, Y_LIMIT=960, STEP=1)
REQ-038 Scenario: boss_exist=1, boss=(100,200), 4 ticks -> FIRE; slot0 x=154, y=260 active; fire_pulse exactly one cycle.
REQ-039 Scenario: 20 ticks, no hits -> slots 0..3 fill in order; 5th fire gives fire_dropped=1 and slot state unchanged.
REQ-040 Scenario: slot0 y=959 plus tick -> slot0 cleared.
REQ-041 Scenario: slot1 active, hit_slot=1 with tick in the same cycle -> slot1 cleared, y unchanged.
REQ-042 Scenario: hit_slot=6 -> ignored.
REQ-043 Scenario: boss_exist drops during FIRE -> FLUSH one cycle, all slots 0, then IDLE; counter restarts from 0 on re-arm.
REQ-044 Scenario: rst asserted mid-ARMED with 3 slots active -> next cycle all outputs at reset values; with BOSS_BULLET_STATS_EN, 300 drops give dropped_count=255.

Source files
------------

// File: rtl/boss_bullet_scheduler.sv
// Boss bullet scheduler: fires from the boss on a tick-driven timer, moves and retires bullet slots.
// Define BOSS_BULLET_STATS_EN to add saturating fired_count/dropped_count outputs.
module boss_bullet_scheduler #(
  parameter int NUM_SLOTS   = 4,
  parameter int FIRE_PERIOD = 480,
  parameter int Y_LIMIT     = 960,
  parameter int STEP        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    boss_exist,
  input  logic [9:0]              boss_x,
  input  logic [9:0]              boss_y,
  input  logic                    hit_valid,
  input  logic [2:0]              hit_slot,
  output logic [NUM_SLOTS-1:0]    slot_active,
  output logic [10*NUM_SLOTS-1:0] slot_x,
  output logic [10*NUM_SLOTS-1:0] slot_y,
  output logic                    fire_pulse,
  output logic                    fire_dropped,
`ifdef BOSS_BULLET_STATS_EN
  output logic [7:0]              fired_count,
  output logic [7:0]              dropped_count,
`endif
  output logic [1:0]              busy_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] FIRE  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0] state;
  logic [9:0] count;
  logic       free_found;
  logic [2:0] free_idx;
  logic       do_fire;

  assign busy_state = state;

  // Lowest-index free slot, judged on slot_active as it stood at the start of the cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_active[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  assign do_fire = (state == FIRE) && boss_exist && free_found;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      fire_pulse   <= 1'b0;
      fire_dropped <= 1'b0;
    end else begin
      fire_pulse   <= 1'b0;
      fire_dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (boss_exist) begin
            state <= ARMED;
            count <= '0;
          end
        end
        ARMED: begin
          if (!boss_exist) begin
            state <= FLUSH;
          end else if (tick) begin
            if (count == 10'(FIRE_PERIOD - 1)) begin
              count <= '0;
              state <= FIRE;
            end else begin
              count <= count + 10'd1;
            end
          end
        end
        FIRE: begin
          if (!boss_exist) begin
            state <= FLUSH;
          end else begin
            state        <= ARMED;
            fire_pulse   <= free_found;
            fire_dropped <= !free_found;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-slot movement, retirement, hit clearing and allocation; a hit beats a same-cycle move.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_active <= '0;
      slot_x      <= '0;
      slot_y      <= '0;
    end else if (state == FLUSH) begin
      slot_active <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        logic [10:0] next_y;
        next_y = {1'b0, slot_y[10*i +: 10]} + 11'(STEP);
        if (slot_active[i]) begin
          if (hit_valid && (hit_slot == 3'(i))) begin
            slot_active[i] <= 1'b0;
          end else if (tick) begin
            slot_y[10*i +: 10] <= next_y[9:0];
            if (next_y >= 11'(Y_LIMIT)) slot_active[i] <= 1'b0;
          end
        end else if (do_fire && (free_idx == 3'(i))) begin
          slot_active[i]     <= 1'b1;
          slot_x[10*i +: 10] <= boss_x + 10'd54;
          slot_y[10*i +: 10] <= boss_y + 10'd60;
        end
      end
    end
  end

`ifdef BOSS_BULLET_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fired_count   <= '0;
      dropped_count <= '0;
    end else begin
      if (fire_pulse && (fired_count != 8'hFF)) fired_count <= fired_count + 8'd1;
      if (fire_dropped && (dropped_count != 8'hFF)) dropped_count <= dropped_count + 8'd1;
    end
  end
`endif

endmodule
